// File: rtl/multicycle_ctrl_cz.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_cz
// Description : Multicycle controller for a 16-bit ADD/NDU/LW/SW/BEQ/JAL core
//               with carry/zero-conditioned ALU writeback and an optional
//               memory ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_cz #(
    parameter bit         MEM_HS   = 1'b1,
    parameter logic [2:0] ALU_ADD  = 3'b000,
    parameter logic [2:0] ALU_SUB  = 3'b001,
    parameter logic [2:0] ALU_NAND = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic [1:0] cz,
    input  logic       zero,
    input  logic       carry,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       regdst,
    output logic [1:0] memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       c_flag,
    output logic       z_flag,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JAL    = 4'd9;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b0110;
    localparam logic [3:0] OP_JAL = 4'b0111;

    logic       rdy;
    logic       wcond;
    logic       pend_c;
    logic       pend_z;
    logic [3:0] next_state;

    // Without the handshake every memory access completes in one cycle
    assign rdy = MEM_HS ? mem_ready : 1'b1;

    // Write condition uses the flags as they stood before this instruction
    always_comb begin
        wcond = 1'b0;
        case (cz)
            2'b00:   wcond = 1'b1;
            2'b10:   wcond = c_flag;
            2'b01:   wcond = z_flag;
            default: wcond = 1'b0;
        endcase
    end

    // Next-state selection
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:   next_state = S_MEMADR;
                    OP_ADD, OP_NDU: next_state = S_EXEC;
                    OP_BEQ:         next_state = S_BRANCH;
                    OP_JAL:         next_state = S_JAL;
                    default:        next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  next_state = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_ALUWB;
            default:  next_state = S_FETCH;
        endcase
    end

    // Moore control decode; strobes are suppressed while reset is held
    always_comb begin
        pcen       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 2'b00;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        case (state)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                irwrite    = rdy;
                pcen       = rdy;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 2'b01;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                alucontrol = (op == OP_NDU) ? ALU_NAND : ALU_ADD;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = wcond;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
            end
            S_JAL: begin
                pcsrc    = 2'b10;
                pcen     = 1'b1;
                memtoreg = 2'b10;
                regwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
    end

    // State, pending ALU flags and architectural flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            pend_c <= 1'b0;
            pend_z <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_EXEC) begin
                pend_c <= carry;
                pend_z <= zero;
            end
            if (state == S_ALUWB && wcond) begin
                if (op == OP_ADD) begin
                    c_flag <= pend_c;
                    z_flag <= pend_z;
                end else if (op == OP_NDU) begin
                    z_flag <= pend_z;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl_cz.md
MULTICYCLE_CTRL_CZ -- requirements
Module: multicycle_ctrl_cz

Interface
REQ-001 SHALL have parameter MEM_HS, default 1, meaning 1 = stall on mem_ready and 0 = memory single-cycle with mem_ready ignored.
REQ-002 SHALL have parameter ALU_ADD, default 3'b000, meaning the alucontrol code for add.
REQ-003 SHALL have parameter ALU_SUB, default 3'b001, meaning the alucontrol code for subtract.
REQ-004 SHALL have parameter ALU_NAND, default 3'b010, meaning the alucontrol code for nand.
REQ-005 SHALL have ports clk in 1 (clock, rising edge) and reset in 1 (synchronous, active-high).
REQ-006 SHALL have ports op in 4 (instr[15:12]) and cz in 2 (instr[1:0]).
REQ-007 SHALL have ports zero in 1 and carry in 1, the ALU result flags valid combinationally in the current cycle.
REQ-008 SHALL have port mem_ready in 1, memory access completes this cycle.
REQ-009 SHALL have outputs pcen, memwrite, irwrite, regwrite, alusrca, iord and regdst, each 1 bit (regdst: 0 = rA instr[11:9], 1 = rC instr[5:3]).
REQ-010 SHALL have outputs memtoreg 2 (00 ALUOut, 01 MDR, 10 PC), alusrcb 2 (00 reg B, 01 const 1, 10 sext imm6, 11 sext imm6 branch), pcsrc 2 (00 ALU, 01 ALUOut, 10 jump target) and alucontrol 3.
REQ-011 SHALL have outputs c_flag 1, z_flag 1 and state 4 (debug).

Function
REQ-012 SHALL decode ADD-family op 0000, NDU-family 0010, LW 0100, SW 0101, BEQ 0110 and JAL 0111.
REQ-013 SHALL encode states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JAL=9, driven on state.
REQ-014 SHALL compute all outputs as Moore functions of state, except pcen in BRANCH and handshake gating; unlisted outputs SHALL be 0.
REQ-015 SHALL in FETCH drive iord=0, alusrca=0, alusrcb=01, alucontrol=ALU_ADD, pcsrc=00 and irwrite=pcen=rdy, where rdy=mem_ready if MEM_HS else 1.
REQ-016 SHALL stay in FETCH while rdy=0 and go to DECODE on rdy=1.
REQ-017 SHALL in DECODE drive alusrca=0, alusrcb=11, alucontrol=ALU_ADD, then go to MEMADR for LW/SW, EXEC for ADD/NDU, BRANCH for BEQ, JAL for JAL, and FETCH for any other opcode (NOP).
REQ-018 SHALL in MEMADR drive alusrca=1, alusrcb=10, alucontrol=ALU_ADD, then go to MEMRD for LW or MEMWR for SW.
REQ-019 SHALL in MEMRD drive iord=1, hold until rdy=1, then go to MEMWB.
REQ-020 SHALL in MEMWB drive regdst=0, memtoreg=01, regwrite=1, then go to FETCH.
REQ-021 SHALL in MEMWR drive iord=1 and memwrite=1 every cycle until rdy=1, then go to FETCH.
REQ-022 SHALL in EXEC drive alusrca=1, alusrcb=00, alucontrol=ALU_ADD (ADD family) or ALU_NAND (NDU family), latch carry/zero into pending registers, then go to ALUWB.
REQ-023 SHALL in ALUWB drive regdst=1, memtoreg=00 and regwrite=wcond, then go to FETCH.
REQ-024 SHALL define wcond from cz: 00 gives 1, 10 gives c_flag, 01 gives z_flag, 11 gives 0 (reserved, no write), evaluated with flag values from before this instruction.
REQ-025 SHALL, when wcond=1, update c_flag and z_flag from the pending values for the ADD family, update z_flag only for the NDU family, and leave both flags unchanged when wcond=0.
REQ-026 SHALL in BRANCH drive alusrca=1, alusrcb=00, alucontrol=ALU_SUB, pcsrc=01 and pcen=zero, then go to FETCH.
REQ-027 SHALL in JAL drive pcsrc=10, pcen=1, regdst=0, memtoreg=10 and regwrite=1, then go to FETCH.
REQ-028 SHALL leave flags unchanged on LW, SW, BEQ, JAL and NOP.
REQ-029 SHALL, when MEM_HS=0, take exactly 1 cycle per state: LW 5, SW 4, ALU 4, BEQ 3, JAL 3 cycles.

Reset
REQ-030 SHALL, with reset=1 at a rising edge, set state=FETCH and c_flag=z_flag=0.
REQ-031 SHALL, while reset=1, force pcen, irwrite, memwrite and regwrite to 0 combinationally.
REQ-032 SHALL, on reset asserted in any state (including MEMWR or MEMRD stalls), abandon the instruction, commit no flag or register write, and restart from FETCH.

Verification
REQ-033 SHALL verify ADD (op=0000, cz=00, carry=1, zero=0, MEM_HS=0): state 0,1,6,7,0, regwrite=1 in ALUWB, then c_flag=1, z_flag=0.
REQ-034 SHALL verify ADC (cz=10) with c_flag=0: regwrite=0 in ALUWB and flags unchanged; repeating it with c_flag=1 gives regwrite=1.
REQ-035 SHALL verify SW with MEM_HS=1 and mem_ready low for 3 cycles in MEMWR: memwrite=1 for 4 cycles, exit to FETCH on the ready cycle.
REQ-036 SHALL verify LW with MEM_HS=0: states 0,1,2,3,4,0, memtoreg=01, regwrite=1 only in MEMWB, flags unchanged.
REQ-037 SHALL verify BEQ with zero=1 gives pcen=1 and pcsrc=01 in BRANCH; with zero=0 it gives pcen=0.
REQ-038 SHALL verify that reset asserted in the second MEMWR stall cycle gives state=0 and memwrite=0 the next cycle, and that op=1111 returns DECODE to FETCH with no writes.
